// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional performance counters: define PIPE_PERF_CTR_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5
`ifdef PIPE_PERF_CTR_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  imem_ready,
   input  logic                  dmem_busy,
   output logic                  pc_write,
   output logic                  pc_sel_redirect,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  exmem_write,
   output logic [1:0]            ctrl_state
`ifdef PIPE_PERF_CTR_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events
`endif
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FETCH_WAIT = 2'd1,
      REDIRECT   = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_load_use;

   assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

   assign ctrl_state = r_state;

   always_comb begin
      pc_write        = 1'b1;
      pc_sel_redirect = 1'b0;
      ifid_write      = 1'b1;
      ifid_flush      = 1'b0;
      idex_write      = 1'b1;
      idex_flush      = 1'b0;
      exmem_write     = 1'b1;
      w_next          = RUN;

      if (!reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         w_next      = RUN;
      end else if (dmem_busy) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         w_next      = MEM_WAIT;
      end else if (r_state == REDIRECT) begin
         // EX holds a bubble here, so branch and load-use cannot be live
         pc_write   = 1'b0;
         ifid_flush = 1'b1;
         w_next     = imem_ready ? RUN : REDIRECT;
      end else if (ex_branch_taken) begin
         pc_sel_redirect = 1'b1;
         ifid_flush      = 1'b1;
         idex_flush      = 1'b1;
         w_next          = imem_ready ? RUN : REDIRECT;
      end else if (w_load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
         w_next     = RUN;
      end else if (!imem_ready) begin
         pc_write   = 1'b0;
         ifid_flush = 1'b1;
         w_next     = FETCH_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next;
      end
   end

`ifdef PIPE_PERF_CTR_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (pc_sel_redirect && (flush_events != '1)) begin
            flush_events <= flush_events + 1'b1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed scoreboard bench for pipeline_hazard_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read;
   logic       ex_branch_taken, imem_ready, dmem_busy;
   logic       pc_write, pc_sel_redirect, ifid_write, ifid_flush;
   logic       idex_write, idex_flush, exmem_write;
   logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CTR_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .imem_ready      (imem_ready),
      .dmem_busy       (dmem_busy),
      .pc_write        (pc_write),
      .pc_sel_redirect (pc_sel_redirect),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_write      (idex_write),
      .idex_flush      (idex_flush),
      .exmem_write     (exmem_write),
      .ctrl_state      (ctrl_state)
`ifdef PIPE_PERF_CTR_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
`endif
   );

   // {pc_write, pc_sel_redirect, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
   localparam logic [6:0] O_RST = 7'b0001010;
   localparam logic [6:0] O_DEF = 7'b1010101;
   localparam logic [6:0] O_LU  = 7'b0000111;
   localparam logic [6:0] O_BR  = 7'b1111111;
   localparam logic [6:0] O_RDR = 7'b0011101;
   localparam logic [6:0] O_MEM = 7'b0000000;
   localparam logic [6:0] O_FW  = 7'b0011101;

   typedef struct {
      string      tag;
      logic [8:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   wire [8:0] obs = {pc_write, pc_sel_redirect, ifid_write, ifid_flush,
                     idex_write, idex_flush, exmem_write, ctrl_state};

   // lu: 0 no load, 1 load-use via rs1, 2 load to x0, 3 load-use via rs2
   task automatic drive(input logic rst, input logic dm, input logic br,
                        input logic im, input int lu);
      reset           = rst;
      dmem_busy       = dm;
      ex_branch_taken = br;
      imem_ready      = im;
      ex_mem_read     = (lu != 0);
      ex_rd           = (lu == 2) ? 5'd0 : 5'd5;
      id_rs1          = (lu == 3) ? 5'd7 : ((lu == 2) ? 5'd0 : 5'd5);
      id_rs2          = (lu == 3) ? 5'd5 : 5'd9;
      id_use_rs1      = 1'b1;
      id_use_rs2      = (lu == 3);
   endtask

   task automatic step(input string tag, input logic rst, input logic dm,
                       input logic br, input logic im, input int lu,
                       input logic [6:0] o, input logic [1:0] st);
      exp_t e;
      drive(rst, dm, br, im, lu);
      e.tag = tag;
      e.v   = {o, st};
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      assert (obs === e.v) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
      @(posedge clk);
      #1;
      step("reset_hold",    0, 0, 0, 1, 0, O_RST, 2'd0);
      step("idle",          1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("load_use_rs1",  1, 0, 0, 1, 1, O_LU,  2'd0);
      step("after_lu",      1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("load_x0",       1, 0, 0, 1, 2, O_DEF, 2'd0);
      step("load_use_rs2",  1, 0, 0, 1, 3, O_LU,  2'd0);
      step("branch_ready",  1, 0, 1, 1, 0, O_BR,  2'd0);
      step("after_branch",  1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("branch_nordy",  1, 0, 1, 0, 0, O_BR,  2'd0);
      step("redirect_1",    1, 0, 0, 0, 0, O_RDR, 2'd2);
      step("redirect_2",    1, 0, 0, 0, 0, O_RDR, 2'd2);
      step("redirect_3",    1, 0, 0, 0, 0, O_RDR, 2'd2);
      step("redirect_rel",  1, 0, 0, 1, 0, O_RDR, 2'd2);
      step("run_after_rdr", 1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("branch_and_lu", 1, 0, 1, 1, 1, O_BR,  2'd0);
      step("idle_2",        1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("dmem_busy_1",   1, 1, 1, 1, 0, O_MEM, 2'd0);
      step("dmem_busy_2",   1, 1, 1, 1, 0, O_MEM, 2'd3);
      step("dmem_busy_3",   1, 1, 1, 1, 0, O_MEM, 2'd3);
      step("dmem_busy_4",   1, 1, 1, 1, 0, O_MEM, 2'd3);
      step("mem_rel_branch",1, 0, 1, 1, 0, O_BR,  2'd3);
      step("idle_3",        1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("fetch_wait_1",  1, 0, 0, 0, 0, O_FW,  2'd0);
      step("fetch_wait_2",  1, 0, 0, 0, 0, O_FW,  2'd1);
      step("reset_in_fw",   0, 0, 0, 0, 0, O_RST, 2'd1);
      step("after_reset",   1, 0, 0, 1, 0, O_DEF, 2'd0);
`ifdef PIPE_PERF_CTR_EN
      n_total++;
      assert ((stall_cycles === 32'd0) && (flush_events === 32'd0)) n_pass++;
      else $error("FAIL ctr_reset observed=%0d/%0d expected=0/0", stall_cycles, flush_events);
`endif
      step("busy_with_lu",  1, 1, 0, 1, 1, O_MEM, 2'd0);
      step("mem_rel_lu",    1, 0, 0, 1, 1, O_LU,  2'd3);
      step("run_after_mem", 1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("reset_ctr",     0, 0, 0, 1, 0, O_RST, 2'd0);
      step("ctr_lu_a",      1, 0, 0, 1, 1, O_LU,  2'd0);
      step("ctr_idle_a",    1, 0, 0, 1, 0, O_DEF, 2'd0);
      step("ctr_lu_b",      1, 0, 0, 1, 3, O_LU,  2'd0);
      step("ctr_branch",    1, 0, 1, 1, 0, O_BR,  2'd0);
      step("ctr_idle_b",    1, 0, 0, 1, 0, O_DEF, 2'd0);
`ifdef PIPE_PERF_CTR_EN
      n_total++;
      assert ((stall_cycles === 32'd2) && (flush_events === 32'd1)) n_pass++;
      else $error("FAIL ctr_count observed=%0d/%0d expected=2/1", stall_cycles, flush_events);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives write-enables and flushes for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch redirects, instruction-fetch wait states and data-memory busy stalls. A small FSM tracks multi-cycle waits so that redirects and bubbles stay correct across memory latency.

Parameters:
REG_ADDR_W, 5, register-index width
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
id_rs1  input  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  input  REG_ADDR_W  rs2 index of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_rd  input  REG_ADDR_W  destination of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch/jump
imem_ready  input  1  fetch data valid this cycle
dmem_busy  input  1  MEM-stage access not complete
pc_write  output  1  PC register update enable
pc_sel_redirect  output  1  PC mux selects EX branch target
ifid_write  output  1  IF/ID load enable (0 = hold)
ifid_flush  output  1  IF/ID clear to NOP/zero
idex_write  output  1  ID/EX load enable
idex_flush  output  1  ID/EX clear (bubble)
exmem_write  output  1  EX/MEM load enable
ctrl_state  output  2  current FSM state

Behaviour:
- States: RUN=0, FETCH_WAIT=1, REDIRECT=2, MEM_WAIT=3. The state register updates on rising clk only.
- reset=0 at an edge: state<=RUN. While reset=0, outputs are forced: all *_write=0, ifid_flush=1, idex_flush=1, pc_sel_redirect=0. The reset applies mid-operation from any state.
- Outputs are combinational from state and inputs; zero added latency.
- Defaults (no event): all *_write=1, flushes=0, pc_sel_redirect=0.
- load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Event priority each cycle: dmem_busy > ex_branch_taken > load_use > !imem_ready.
- dmem_busy=1 (any state): pc_write=ifid_write=idex_write=exmem_write=0 and no flushes. Next state is MEM_WAIT. MEM_WAIT persists while dmem_busy=1.
- MEM_WAIT with dmem_busy=0: the remaining priority rules are evaluated as in RUN in the same cycle. A branch held in EX during the wait is therefore redirected on the release cycle.
- ex_branch_taken (RUN, FETCH_WAIT or release from MEM_WAIT): pc_sel_redirect=1, pc_write=1, ifid_flush=1, idex_flush=1.
  - Next state is RUN if imem_ready=1, else REDIRECT.
- REDIRECT: pc_write=0, ifid_flush=1, idex_flush=0. Stays in REDIRECT until imem_ready=1, then RUN. A new ex_branch_taken cannot occur here, because EX holds a bubble.
- load_use (no higher event): pc_write=0, ifid_write=0, idex_flush=1. Inserts exactly one bubble; state stays RUN.
- !imem_ready (no higher event): pc_write=0, ifid_flush=1 (bubble to ID). Downstream stages advance. Next state is FETCH_WAIT until imem_ready=1.
- ex_rd==0 never triggers load_use.
- Simultaneous load_use and branch: the branch wins, and the load-use bubble is discarded by the flush.

Optional Feature:
PIPE_PERF_CTR_EN
- Defined: adds output ports stall_cycles[CNT_W-1:0] and flush_events[CNT_W-1:0].
  - stall_cycles increments on every non-reset cycle with pc_write=0.
  - flush_events increments on every cycle with ex_branch_taken accepted (pc_sel_redirect=1).
  - Both counters saturate at all-ones and clear to 0 on reset=0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; RUN kept. Repeating with ex_rd=0 -> no stall.
- Branch with imem_ready=1: ex_branch_taken pulse -> same cycle pc_sel_redirect=1, ifid_flush=1, idex_flush=1; next cycle defaults.
- Branch with imem_ready=0 for 3 cycles -> REDIRECT for 3 cycles with ifid_flush=1, pc_write=0; RUN after imem_ready=1.
- dmem_busy=1 for 4 cycles while ex_branch_taken=1 -> all writes 0 for 4 cycles in MEM_WAIT; redirect on the 5th cycle.
- reset=0 asserted while in FETCH_WAIT -> next edge ctrl_state=0; forced reset outputs observed; counters=0 (with PIPE_PERF_CTR_EN).
- PIPE_PERF_CTR_EN defined: 2 load-use stalls + 1 branch -> stall_cycles=2, flush_events=1.
